// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32I ALU issue controller: decode, drive ALU, capture, writeback handshake
module alu_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [3:0]       alu_op,
    input  logic [XLEN-1:0]  alu_out,
    input  logic [3:0]       alu_flags,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [XLEN-1:0]  res_data,
    output logic [4:0]       res_rd,
    output logic             res_wen,
    output logic [3:0]       res_flags,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t r_state;
    state_t w_next;

    logic [XLEN-1:0]  r_alu_a;
    logic [XLEN-1:0]  r_alu_b;
    logic [3:0]       r_alu_op;
    logic             r_err;
    logic [4:0]       r_rd;
    logic [XLEN-1:0]  r_res_data;
    logic [4:0]       r_res_rd;
    logic             r_res_wen;
    logic [3:0]       r_res_flags;
    logic             r_res_err;
    logic [CNT_W-1:0] r_op_count;

    logic [6:0]       w_opcode;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    logic             w_is_r;
    logic             w_is_i;
    logic             w_legal;
    logic             w_shift;
    logic [3:0]       w_op;
    logic [4:0]       w_shamt;
    logic [XLEN-1:0]  w_dec_a;
    logic [XLEN-1:0]  w_dec_b;
    logic             w_accept;
    logic             w_resp_hs;
    logic             w_unused;

    assign w_opcode  = in_instr[6:0];
    assign w_f3      = in_instr[14:12];
    assign w_f7      = in_instr[31:25];
    assign w_is_r    = (w_opcode == OPC_R);
    assign w_is_i    = (w_opcode == OPC_I);
    assign w_shamt   = w_is_i ? in_instr[24:20] : in_rs2[4:0];
    // Register-file source fields are resolved upstream; the operands arrive already read.
    assign w_unused  = ^in_instr[19:15];

    always_comb begin
        w_op    = 4'b0000;
        w_legal = 1'b0;
        w_shift = 1'b0;
        if (w_is_r || w_is_i) begin
            case (w_f3)
                3'b000: begin
                    if (w_is_i || (w_f7 == F7_ZERO)) begin
                        w_op    = 4'b0000;
                        w_legal = 1'b1;
                    end else if (w_f7 == F7_ALT) begin
                        w_op    = 4'b1000;
                        w_legal = 1'b1;
                    end
                end
                3'b001: begin
                    w_shift = 1'b1;
                    w_op    = 4'b0001;
                    w_legal = (w_f7 == F7_ZERO);
                end
                3'b101: begin
                    w_shift = 1'b1;
                    if (w_f7 == F7_ZERO) begin
                        w_op    = 4'b0101;
                        w_legal = 1'b1;
                    end else if (w_f7 == F7_ALT) begin
                        w_op    = 4'b1101;
                        w_legal = 1'b1;
                    end
                end
                default: begin
                    w_op    = {1'b0, w_f3};
                    w_legal = w_is_i || (w_f7 == F7_ZERO);
                end
            endcase
        end
    end

    always_comb begin
        w_dec_a = '0;
        w_dec_b = '0;
        if (w_legal) begin
            w_dec_a = in_rs1;
            if (w_shift) begin
                w_dec_b = {{(XLEN-5){1'b0}}, w_shamt};
            end else if (w_is_i) begin
                w_dec_b = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
            end else begin
                w_dec_b = in_rs2;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_resp_hs = (r_state == S_RESP) && res_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ALU operands are registered at accept so they are stable through EXEC and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_alu_op <= 4'b0000;
            r_err    <= 1'b0;
            r_rd     <= 5'd0;
        end else if (w_accept) begin
            r_alu_a  <= w_dec_a;
            r_alu_b  <= w_dec_b;
            r_alu_op <= w_legal ? w_op : 4'b0000;
            r_err    <= !w_legal;
            r_rd     <= in_instr[11:7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_data  <= '0;
            r_res_rd    <= 5'd0;
            r_res_wen   <= 1'b0;
            r_res_flags <= 4'b0000;
            r_res_err   <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_res_data  <= r_err ? '0 : alu_out;
            r_res_flags <= r_err ? 4'b0000 : alu_flags;
            r_res_rd    <= r_rd;
            r_res_wen   <= !r_err && (r_rd != 5'd0);
            r_res_err   <= r_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= '0;
        end else if (w_resp_hs && !r_res_err) begin
            r_op_count <= r_op_count + 1'b1;
        end
    end

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign res_data  = r_res_data;
    assign res_rd    = r_res_rd;
    assign res_wen   = r_res_wen;
    assign res_flags = r_res_flags;
    assign res_err   = r_res_err;
    assign op_count  = r_op_count;

endmodule
